// File: rtl/video_pkg.sv
// Shared types for the video timing and test-pattern source.
// Pattern modes, bar colour table and timing size helpers.
package video_pkg;

  typedef enum logic [1:0] {
    PAT_GRADIENT = 2'd0,
    PAT_BARS     = 2'd1,
    PAT_CHECKER  = 2'd2,
    PAT_SCROLL   = 2'd3
  } pattern_mode_e;

  // {R,G,B} on/off per bar; entry 0 is the leftmost bar
  localparam logic [7:0][2:0] BAR_LUT = {
    3'b000, 3'b001, 3'b100, 3'b101,
    3'b010, 3'b011, 3'b110, 3'b111
  };

  localparam int FRAME_W = 8;

  function automatic int vt_total(
    input int act,
    input int fp,
    input int syn,
    input int bp
  );
    return act + fp + syn + bp;
  endfunction

  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Pixel/line counters with sync, data-enable and frame marker decode.
// Decodes are combinational from the current (col,row) state.
module video_timing_counter
  import video_pkg::*;
#(
  parameter int H_ACTIVE = 80,
  parameter int H_FP     = 4,
  parameter int H_SYNC   = 4,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 60,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 4,
  parameter int HW =
    cnt_width(vt_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
  parameter int VW =
    cnt_width(vt_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
  input  logic          i_clk,
  input  logic          i_rst,
  output logic [HW-1:0] o_col,
  output logic [VW-1:0] o_row,
  output logic          o_de,
  output logic          o_hs,
  output logic          o_vs,
  output logic          o_sof,
  output logic          o_frame_end
);

  localparam int H_TOTAL =
    vt_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    vt_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END =
    HW'(H_ACTIVE + H_FP + H_SYNC);

  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END =
    VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] r_col;
  logic [VW-1:0] r_row;
  logic          w_col_last;
  logic          w_row_last;

  assign w_col_last = (r_col == H_LAST);
  assign w_row_last = (r_row == V_LAST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_col_last) begin
      r_col <= '0;
      r_row <= w_row_last ? '0 : r_row + 1'b1;
    end else begin
      r_col <= r_col + 1'b1;
    end
  end

  assign o_col = r_col;
  assign o_row = r_row;

  assign o_de  = (r_col < H_ACT) && (r_row < V_ACT);
  assign o_hs  = (r_col >= HS_BEG) && (r_col < HS_END);
  assign o_vs  = (r_row >= VS_BEG) && (r_row < VS_END);
  assign o_sof = (r_col == '0) && (r_row == '0);

  assign o_frame_end = w_col_last && w_row_last;

endmodule

// File: rtl/video_timing_pattern_gen.sv
// Video timing source with runtime-selectable test patterns.
// Outputs are registered one clock after the (col,row) counter state.
module video_timing_pattern_gen
  import video_pkg::*;
#(
  parameter int   H_ACTIVE = 80,
  parameter int   H_FP     = 4,
  parameter int   H_SYNC   = 4,
  parameter int   H_BP     = 2,
  parameter int   V_ACTIVE = 60,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 3,
  parameter int   V_BP     = 4,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   CW       = 4,
  parameter int   SQ_LOG2  = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      mode_i,
  output logic            de_o,
  output logic            hsync_o,
  output logic            vsync_o,
  output logic            sof_o,
  output logic [3*CW-1:0] pix_o
);

  localparam int H_TOTAL =
    vt_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL =
    vt_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW = cnt_width(H_TOTAL);
  localparam int VW = cnt_width(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = cnt_width(BAR_W);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  localparam logic [CW-1:0] ONES = '1;

  if (H_ACTIVE % 8 != 0) begin : g_bad_hact
    $error("H_ACTIVE must be a multiple of 8");
  end
  if (H_ACTIVE < 8 || H_FP < 1 || H_SYNC < 1 ||
      H_BP < 1) begin : g_bad_h
    $error("horizontal widths must be >= 1");
  end
  if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 ||
      V_BP < 1) begin : g_bad_v
    $error("vertical widths must be >= 1");
  end
  if (CW < 1) begin : g_bad_cw
    $error("CW must be >= 1");
  end
  if (SQ_LOG2 < 0 || SQ_LOG2 >= HW) begin : g_bad_sq
    $error("SQ_LOG2 must be below the column width");
  end

  logic [HW-1:0]  w_col;
  logic [VW-1:0]  w_row;
  logic           w_de;
  logic           w_hs;
  logic           w_vs;
  logic           w_sof;
  logic           w_frame_end;

  video_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .HW       (HW),
    .VW       (VW)
  ) u_cnt (
    .i_clk       (clk_i),
    .i_rst       (rst_i),
    .o_col       (w_col),
    .o_row       (w_row),
    .o_de        (w_de),
    .o_hs        (w_hs),
    .o_vs        (w_vs),
    .o_sof       (w_sof),
    .o_frame_end (w_frame_end)
  );

  pattern_mode_e        r_mode;
  logic [FRAME_W-1:0]   r_frame;
  logic [BW-1:0]        r_bar_cnt;
  logic [2:0]           r_bar_idx;

  // Mode and animation counter change only between frames
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_mode  <= PAT_GRADIENT;
      r_frame <= '0;
    end else if (w_frame_end) begin
      r_mode  <= pattern_mode_e'(mode_i);
      r_frame <= r_frame + 1'b1;
    end
  end

  // Bar index tracks the current column without a divider
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (w_col == H_LAST) begin
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (r_bar_cnt == BAR_LAST) begin
      r_bar_cnt <= '0;
      r_bar_idx <= r_bar_idx + 3'd1;
    end else begin
      r_bar_cnt <= r_bar_cnt + 1'b1;
    end
  end

  logic [CW-1:0] w_x;
  logic [CW-1:0] w_y;
  logic [CW-1:0] w_fr;
  logic [CW-1:0] w_sx;
  logic          w_cx;
  logic          w_cy;
  logic [2:0]    w_bar;

  if (CW <= HW) begin : g_x_trunc
    assign w_x = w_col[CW-1:0];
  end else begin : g_x_ext
    assign w_x = {{(CW-HW){1'b0}}, w_col};
  end

  if (CW <= VW) begin : g_y_trunc
    assign w_y = w_row[CW-1:0];
  end else begin : g_y_ext
    assign w_y = {{(CW-VW){1'b0}}, w_row};
  end

  if (CW <= FRAME_W) begin : g_f_trunc
    assign w_fr = r_frame[CW-1:0];
  end else begin : g_f_ext
    assign w_fr = {{(CW-FRAME_W){1'b0}}, r_frame};
  end

  if (SQ_LOG2 < VW) begin : g_cy
    assign w_cy = w_row[SQ_LOG2];
  end else begin : g_cy_zero
    assign w_cy = 1'b0;
  end

  assign w_cx  = w_col[SQ_LOG2];
  assign w_sx  = w_x + w_fr;
  assign w_bar = BAR_LUT[r_bar_idx];

  logic [3*CW-1:0] w_pix;

  always_comb begin
    w_pix = '0;
    unique case (r_mode)
      PAT_GRADIENT: w_pix = {w_x, w_y, ONES};
      PAT_BARS: w_pix = {{CW{w_bar[2]}},
                         {CW{w_bar[1]}},
                         {CW{w_bar[0]}}};
      PAT_CHECKER: w_pix = (w_cx ^ w_cy) ? {3{ONES}} : '0;
      PAT_SCROLL: w_pix = {w_sx, w_y, ONES};
      default: w_pix = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      de_o    <= 1'b0;
      sof_o   <= 1'b0;
      hsync_o <= ~HS_POL;
      vsync_o <= ~VS_POL;
      pix_o   <= '0;
    end else begin
      de_o    <= w_de;
      sof_o   <= w_sof;
      hsync_o <= w_hs ? HS_POL : ~HS_POL;
      vsync_o <= w_vs ? VS_POL : ~VS_POL;
      pix_o   <= w_de ? w_pix : '0;
    end
  end

endmodule

// File: tb/tb_video_timing_pattern_gen.sv
// Scoreboard bench for video_timing_pattern_gen.
// Stimulus queues expected outputs; a negedge monitor pops and compares.
module tb_video_timing_pattern_gen;

  localparam int HT = 24;
  localparam int FT = 288;

  typedef struct {
    int          when;
    string       name;
    logic [3:0]  ctl;
    logic [11:0] pix;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  mode_i = 2'd0;
  logic        de_o;
  logic        hsync_o;
  logic        vsync_o;
  logic        sof_o;
  logic [11:0] pix_o;

  video_timing_pattern_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (2), .H_BP (4),
    .V_ACTIVE (8),  .V_FP (1), .V_SYNC (1), .V_BP (2),
    .HS_POL (1'b1), .VS_POL (1'b1),
    .CW (4), .SQ_LOG2 (2)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .mode_i  (mode_i),
    .de_o    (de_o),
    .hsync_o (hsync_o),
    .vsync_o (vsync_o),
    .sof_o   (sof_o),
    .pix_o   (pix_o)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_q = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_q <= rst_i;

  exp_t q[$];
  int   base = 0;
  bit   done = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h want=%0h",
                  nm, cyc, got, want);
  endtask

  // Monitor: scoreboard pops plus per-frame properties
  bit armed = 1'b0;
  bit have_sof = 1'b0;
  int last_sof = 0;
  int de_cnt = 0;
  always @(negedge clk) begin : mon
    int i;
    i = 0;
    while (i < q.size()) begin
      if (q[i].when == cyc) begin
        check({q[i].name, "_ctl"},
              {28'd0, de_o, hsync_o, vsync_o, sof_o},
              {28'd0, q[i].ctl});
        check({q[i].name, "_pix"},
              {20'd0, pix_o}, {20'd0, q[i].pix});
        q.delete(i);
      end else if (q[i].when < cyc) begin
        check({q[i].name, "_missed"}, cyc, q[i].when);
        q.delete(i);
      end else begin
        i++;
      end
    end
    if (rst_q) begin
      armed = 1'b1;
      have_sof = 1'b0;
      de_cnt = 0;
    end else if (armed) begin
      if (de_o === 1'b0)
        check("blank_pix", {20'd0, pix_o}, 32'd0);
      if (sof_o === 1'b1) begin
        if (have_sof) begin
          check("sof_period", cyc - last_sof, FT);
          check("de_per_frame", de_cnt, 128);
        end
        have_sof = 1'b1;
        last_sof = cyc;
        de_cnt = 0;
      end
      if (de_o === 1'b1) de_cnt++;
    end
    if (done) begin
      check("queue_drained", q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
    end
  end

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input int w, input string nm,
                      input logic [3:0] ctl,
                      input logic [11:0] pix);
    q.push_back('{w, nm, ctl, pix});
  endtask

  // ctl = {de, hsync, vsync, sof}
  task automatic at(input int f, input int col,
                    input int row, input string nm,
                    input logic [3:0] ctl,
                    input logic [11:0] pix);
    push(base + f * FT + row * HT + col, nm, ctl, pix);
  endtask

  function automatic logic [15:0] model(input int col,
                                        input int row,
                                        input int mode,
                                        input int fq);
    logic [11:0] bars [8];
    logic        de;
    logic [3:0]  ctl;
    logic [11:0] px;
    bars = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
             12'hF0F, 12'hF00, 12'h00F, 12'h000};
    de  = (col < 16) && (row < 8);
    ctl = {de, (col == 18 || col == 19), (row == 9),
           (col == 0 && row == 0)};
    px  = 12'h000;
    if (de) begin
      case (mode)
        0: px = {4'(col), 4'(row), 4'hF};
        1: px = bars[col / 2];
        2: px = (((col / 4) % 2) != ((row / 4) % 2)) ?
                12'hFFF : 12'h000;
        default: px = {4'(col + fq), 4'(row), 4'hF};
      endcase
    end
    return {ctl, px};
  endfunction

  task automatic push_frame(input int f, input int mode);
    logic [15:0] m;
    for (int k = 0; k < FT; k++) begin
      m = model(k % HT, k / HT, mode, f % 256);
      push(base + f * FT + k, $sformatf("f%0d_k%0d", f, k),
           m[15:12], m[11:0]);
    end
  endtask

  initial begin : stim
    int c0;
    rst_i = 1'b1;
    mode_i = 2'd0;
    wait_cyc(2);
    rst_i = 1'b0;
    wait_cyc(103);
    c0 = cyc;
    for (int k = 1; k <= 3; k++)
      push(c0 + k, "rst_hold", 4'b0000, 12'h000);
    rst_i = 1'b1;
    mode_i = 2'd1;
    wait_cyc(c0 + 3);
    rst_i = 1'b0;
    mode_i = 2'd0;
    base = cyc + 1;

    push_frame(0, 0);
    at(0, 0, 0, "rel_sof", 4'b1001, 12'h00F);
    at(0, 1, 0, "grad_x1", 4'b1000, 12'h10F);
    at(0, 15, 7, "grad_last", 4'b1000, 12'hF7F);
    at(0, 5, 5, "grad_mid", 4'b1000, 12'h55F);
    at(0, 16, 0, "hfp", 4'b0000, 12'h000);
    at(0, 17, 0, "hfp_end", 4'b0000, 12'h000);
    at(0, 18, 0, "hs_on", 4'b0100, 12'h000);
    at(0, 19, 0, "hs_end", 4'b0100, 12'h000);
    at(0, 20, 0, "hs_off", 4'b0000, 12'h000);
    at(0, 0, 8, "vfp", 4'b0000, 12'h000);
    at(0, 0, 9, "vs_on", 4'b0010, 12'h000);
    at(0, 18, 9, "hs_vs", 4'b0110, 12'h000);
    at(0, 23, 9, "vs_last", 4'b0010, 12'h000);
    at(0, 0, 10, "vs_off", 4'b0000, 12'h000);

    wait_cyc(base + 72);
    mode_i = 2'd3;
    push_frame(1, 3);
    at(1, 0, 0, "scroll_f1", 4'b1001, 12'h10F);
    at(1, 15, 0, "scroll_wrap", 4'b1000, 12'h00F);
    at(1, 3, 2, "scroll_32", 4'b1000, 12'h42F);

    wait_cyc(base + FT + 72);
    mode_i = 2'd1;
    push_frame(2, 1);
    at(2, 0, 0, "bar_white0", 4'b1001, 12'hFFF);
    at(2, 1, 0, "bar_white1", 4'b1000, 12'hFFF);
    at(2, 2, 0, "bar_yel2", 4'b1000, 12'hFF0);
    at(2, 3, 0, "bar_yel3", 4'b1000, 12'hFF0);
    at(2, 4, 3, "bar_cyan", 4'b1000, 12'h0FF);
    at(2, 6, 0, "bar_green", 4'b1000, 12'h0F0);
    at(2, 8, 0, "bar_mag", 4'b1000, 12'hF0F);
    at(2, 10, 0, "bar_red", 4'b1000, 12'hF00);
    at(2, 12, 0, "bar_blue", 4'b1000, 12'h00F);
    at(2, 14, 0, "bar_blk14", 4'b1000, 12'h000);
    at(2, 15, 0, "bar_blk15", 4'b1000, 12'h000);
    at(2, 16, 0, "bar_blank", 4'b0000, 12'h000);

    wait_cyc(base + 2 * FT + 72);
    mode_i = 2'd2;
    push_frame(3, 2);
    at(3, 0, 0, "chk_00", 4'b1001, 12'h000);
    at(3, 3, 0, "chk_30", 4'b1000, 12'h000);
    at(3, 4, 0, "chk_40", 4'b1000, 12'hFFF);
    at(3, 4, 4, "chk_44", 4'b1000, 12'h000);
    at(3, 0, 4, "chk_04", 4'b1000, 12'hFFF);

    wait_cyc(base + 3 * FT + 72);
    mode_i = 2'd3;
    at(255, 0, 0, "scroll_f255", 4'b1001, 12'hF0F);
    at(255, 5, 2, "scroll_f255_52", 4'b1000, 12'h42F);
    at(256, 0, 0, "scroll_wrap0", 4'b1001, 12'h00F);
    at(256, 5, 2, "scroll_f256_52", 4'b1000, 12'h52F);
    at(257, 0, 0, "scroll_f257", 4'b1001, 12'h10F);

    wait_cyc(base + 258 * FT);
    done = 1'b1;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog cyc=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

endmodule
